// File: rtl/monitor_3lxnpc.sv
// monitor_3lxnpc
// ---------------------------------------------------------------------------
// Gate-feedback monitor for one 3-level NPC / T-type (NPP) / ANPC leg.
// The six switch-state feedback lines are double-flop synchronized. The
// applied leg level is then decoded per topology and passed through a
// programmable glitch filter. Accepted level updates are counted, and
// persistent shoot-through patterns are latched as faults.
//
// Ports
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   ce_i          clock enable; every register (synchronizers included) holds when low
//   s_1_i..s_6_i  switch feedback, 1 = switch on, asynchronous to clk_i
//   npc_type_i    topology: 0 disabled, 1 NPC, 2 NPP (T-type), 3 ANPC
//   t_filt_i      level filter length in ce cycles
//   t_short_i     shoot-through persistence threshold in ce cycles
//   fault_clr_i   level-sensitive fault clear request
//   v_lev_o       filtered level: 00 zero, 01 positive, 10 negative, 11 indeterminate
//   trans_cnt_o   saturating count of v_lev updates (CNT_W bits, 16 by default)
//   fault_o       latched shoot-through fault
//   fault_code_o  sticky fault cause bits {S4&S6, S1&S5, leg short}
// ---------------------------------------------------------------------------
module monitor_3lxnpc #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ce_i,
  input  logic             s_1_i,
  input  logic             s_2_i,
  input  logic             s_3_i,
  input  logic             s_4_i,
  input  logic             s_5_i,
  input  logic             s_6_i,
  input  logic [1:0]       npc_type_i,
  input  logic [7:0]       t_filt_i,
  input  logic [7:0]       t_short_i,
  input  logic             fault_clr_i,
  output logic [1:0]       v_lev_o,
  output logic [CNT_W-1:0] trans_cnt_o,
  output logic             fault_o,
  output logic [2:0]       fault_code_o
);

  typedef enum logic [1:0] {
    NOOUT = 2'd0,
    NPC   = 2'd1,
    NPP   = 2'd2,
    ANPC  = 2'd3
  } npc_type_e;

  localparam logic [1:0] LEV_Z = 2'b00;
  localparam logic [1:0] LEV_P = 2'b01;
  localparam logic [1:0] LEV_N = 2'b10;
  localparam logic [1:0] LEV_X = 2'b11;

  // State registers
  logic [5:0]       sync1_q, sync2_q;
  logic [1:0]       cand_q, cand_d;
  logic [7:0]       fcnt_q, fcnt_d;
  logic [1:0]       v_lev_q, v_lev_d;
  logic [CNT_W-1:0] trans_cnt_q, trans_cnt_d;
  logic [7:0]       scnt_q, scnt_d;
  logic             fault_q, fault_d;
  logic [2:0]       fault_code_q, fault_code_d;

  // Combinational decode
  npc_type_e  npc_type;
  logic [5:0] s_raw;
  logic [5:0] s_eff;
  logic [1:0] raw_lev;
  logic [2:0] sc;
  logic       s1, s2, s3, s4, s5, s6;

  assign s_raw    = {s_6_i, s_5_i, s_4_i, s_3_i, s_2_i, s_1_i};
  assign npc_type = npc_type_e'(npc_type_i);

  // Classic NPC has no outer clamp switches; their feedback is ignored.
  always_comb begin
    s_eff = sync2_q;
    if (npc_type == NPC) begin
      s_eff[5:4] = 2'b00;
    end
  end

  assign s1 = s_eff[0];
  assign s2 = s_eff[1];
  assign s3 = s_eff[2];
  assign s4 = s_eff[3];
  assign s5 = s_eff[4];
  assign s6 = s_eff[5];

  // Raw level and shoot-through decode. P, N and Z are mutually exclusive
  // in every topology, so the if-chain order is immaterial.
  always_comb begin
    raw_lev = LEV_X;
    sc      = 3'b000;
    unique case (npc_type)
      NPC, ANPC: begin
        if (s1 && s2 && !s3 && !s4) begin
          raw_lev = LEV_P;
        end else if (s3 && s4 && !s1 && !s2) begin
          raw_lev = LEV_N;
        end else if (!s1 && !s4 && (s2 || s3)) begin
          raw_lev = LEV_Z;
        end
        sc[0] = s1 & s2 & s3 & s4;
        if (npc_type == ANPC) begin
          sc[1] = s1 & s5;
          sc[2] = s4 & s6;
        end
      end
      NPP: begin
        if (s1 && !s4) begin
          raw_lev = LEV_P;
        end else if (s4 && !s1) begin
          raw_lev = LEV_N;
        end else if (!s1 && !s4 && (s2 || s3)) begin
          raw_lev = LEV_Z;
        end
        sc[0] = s1 & s4;
      end
      default: begin
        raw_lev = LEV_X;
        sc      = 3'b000;
      end
    endcase
  end

  // Level filter: a level must stay unchanged on the raw decode long enough
  // for fcnt to reach t_filt before it is copied to v_lev.
  always_comb begin
    cand_d      = cand_q;
    fcnt_d      = fcnt_q;
    v_lev_d     = v_lev_q;
    trans_cnt_d = trans_cnt_q;
    if (raw_lev != cand_q) begin
      cand_d = raw_lev;
      fcnt_d = 8'd0;
    end else if (fcnt_q < t_filt_i) begin
      fcnt_d = fcnt_q + 8'd1;
    end else if (v_lev_q != cand_q) begin
      v_lev_d = cand_q;
      if (trans_cnt_q != {CNT_W{1'b1}}) begin
        trans_cnt_d = trans_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Shoot-through persistence and fault latch. The clear only acts when no
  // short is present, which also makes detection win over a same-edge clear.
  // The >= comparison keeps detection working if t_short is lowered below
  // the current count.
  always_comb begin
    scnt_d       = scnt_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    if (sc == 3'b000) begin
      scnt_d = 8'd0;
      if (fault_clr_i) begin
        fault_d      = 1'b0;
        fault_code_d = 3'b000;
      end
    end else begin
      if (scnt_q < t_short_i) begin
        scnt_d = scnt_q + 8'd1;
      end else begin
        fault_d = 1'b1;
      end
      if (fault_q || (scnt_q >= t_short_i)) begin
        fault_code_d = fault_code_q | sc;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q      <= 6'd0;
      sync2_q      <= 6'd0;
      cand_q       <= LEV_X;
      fcnt_q       <= 8'd0;
      v_lev_q      <= LEV_X;
      trans_cnt_q  <= '0;
      scnt_q       <= 8'd0;
      fault_q      <= 1'b0;
      fault_code_q <= 3'b000;
    end else if (ce_i) begin
      sync1_q      <= s_raw;
      sync2_q      <= sync1_q;
      cand_q       <= cand_d;
      fcnt_q       <= fcnt_d;
      v_lev_q      <= v_lev_d;
      trans_cnt_q  <= trans_cnt_d;
      scnt_q       <= scnt_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign v_lev_o      = v_lev_q;
  assign trans_cnt_o  = trans_cnt_q;
  assign fault_o      = fault_q;
  assign fault_code_o = fault_code_q;

endmodule
